// File: rtl/counter_ctrl.sv
// Sequencer for the up/down counter: synchronises and debounces the buttons, runs PAUSE/RUN/LOAD, emits a slow count tick.
// All outputs are registered; a button event is acted on 2+DEBOUNCE_CYCLES+1 cycles after its raw edge, with no backpressure.
module counter_ctrl #(
    parameter int CLK_HZ          = 50000000,
    parameter int TICK_HZ         = 1,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DATA_W          = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_btn,
    input  logic              run_btn,
    input  logic              up_down_sw,
    input  logic [DATA_W-1:0] data_sw,
    output logic              cnt_en,
    output logic              cnt_load,
    output logic              cnt_dir,
    output logic [DATA_W-1:0] cnt_data,
    output logic              running
);

    localparam int PERIOD = CLK_HZ / TICK_HZ;
    localparam int PW     = $clog2(PERIOD);
    localparam int DW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SW     = DATA_W + 3;
    localparam logic [PW-1:0] PRESC_TC = PW'(PERIOD - 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {S_PAUSE, S_RUN, S_LOAD} state_t;

    // Bit 0 = load button, bit 1 = run button, bit 2 = direction, upper bits = load data.
    logic [SW-1:0]        sync1_q, sync2_q;
    logic [1:0]           lvl_q, lvl_prev_q;
    logic [1:0][DW-1:0]   deb_q;
    logic                 load_evt, run_evt;

    state_t               state_q, ret_q;
    logic [PW-1:0]        presc_q;
    logic                 cnt_en_q, cnt_load_q, cnt_dir_q, running_q;
    logic [DATA_W-1:0]    cnt_data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {data_sw, up_down_sw, run_btn, load_btn};
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lvl_q      <= '0;
            lvl_prev_q <= '0;
            deb_q      <= '0;
        end else begin
            lvl_prev_q <= lvl_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == lvl_q[i]) begin
                    deb_q[i] <= '0;
                end else if (deb_q[i] == DEB_LAST) begin
                    lvl_q[i] <= sync2_q[i];
                    deb_q[i] <= '0;
                end else begin
                    deb_q[i] <= deb_q[i] + DW'(1);
                end
            end
        end
    end

    assign load_evt = lvl_q[0] & ~lvl_prev_q[0];
    assign run_evt  = lvl_q[1] & ~lvl_prev_q[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_PAUSE;
            ret_q      <= S_PAUSE;
            presc_q    <= '0;
            cnt_en_q   <= 1'b0;
            cnt_load_q <= 1'b0;
            cnt_dir_q  <= 1'b0;
            cnt_data_q <= '0;
            running_q  <= 1'b0;
        end else begin
            cnt_en_q   <= 1'b0;
            cnt_load_q <= 1'b0;
            cnt_dir_q  <= sync2_q[2];
            case (state_q)
                S_LOAD: begin
                    state_q   <= ret_q;
                    presc_q   <= '0;
                    running_q <= (ret_q == S_RUN);
                end
                default: begin
                    // Load wins a tie; the run toggle is folded into the return state.
                    if (load_evt) begin
                        state_q    <= S_LOAD;
                        ret_q      <= run_evt ? ((state_q == S_RUN) ? S_PAUSE : S_RUN) : state_q;
                        cnt_load_q <= 1'b1;
                        cnt_data_q <= sync2_q[SW-1:3];
                        presc_q    <= '0;
                        running_q  <= (state_q == S_RUN);
                    end else if (run_evt) begin
                        state_q   <= (state_q == S_RUN) ? S_PAUSE : S_RUN;
                        presc_q   <= '0;
                        running_q <= (state_q != S_RUN);
                    end else if (state_q == S_RUN) begin
                        if (presc_q == PRESC_TC) begin
                            presc_q  <= '0;
                            cnt_en_q <= 1'b1;
                        end else begin
                            presc_q <= presc_q + PW'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign cnt_en   = cnt_en_q;
    assign cnt_load = cnt_load_q;
    assign cnt_dir  = cnt_dir_q;
    assign cnt_data = cnt_data_q;
    assign running  = running_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl with a small clock-rate model: directed scenarios plus randomised button traffic.
module tb_counter_ctrl;

    localparam int P = 10;
    localparam int D = 4;

    logic       clk, rst, load_btn, run_btn, up_down_sw;
    logic [3:0] data_sw;
    logic       cnt_en, cnt_load, cnt_dir, running;
    logic [3:0] cnt_data;

    counter_ctrl #(.CLK_HZ(10), .TICK_HZ(1), .DEBOUNCE_CYCLES(D), .DATA_W(4)) dut (
        .clk(clk), .rst(rst), .load_btn(load_btn), .run_btn(run_btn),
        .up_down_sw(up_down_sw), .data_sw(data_sw), .cnt_en(cnt_en),
        .cnt_load(cnt_load), .cnt_dir(cnt_dir), .cnt_data(cnt_data), .running(running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, $signed(got), $signed(exp), $time);
        end
    endtask

    // Reference model: raw samples are seen two clocks late, a button level is accepted after
    // D consecutive disagreeing samples, and its rising edge is acted on one clock later.
    typedef struct packed {
        logic       ld;
        logic       rn;
        logic       dir;
        logic [3:0] dat;
    } raw_t;

    raw_t hist[$];
    int   m_stable[2];
    bit   m_lvl[2];
    bit   m_evt[2];
    bit   m_mode, m_in_load, m_ret;
    int   m_run_age;
    bit   e_en, e_ld, e_dir, e_run;
    bit [3:0] e_dat;

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 3; i++) hist.push_front(raw_t'(0));
        for (int i = 0; i < 2; i++) begin
            m_stable[i] = 0; m_lvl[i] = 0; m_evt[i] = 0;
        end
        m_mode = 0; m_in_load = 0; m_ret = 0; m_run_age = 0;
        e_en = 0; e_ld = 0; e_dir = 0; e_run = 0; e_dat = '0;
    endtask

    task automatic model_step();
        raw_t r, s;
        bit   ev_ld, ev_rn, smp;
        r = '{ld: load_btn, rn: run_btn, dir: up_down_sw, dat: data_sw};
        hist.push_front(r);
        while (hist.size() > 3) void'(hist.pop_back());
        s = hist[2];
        ev_ld = m_evt[0];
        ev_rn = m_evt[1];
        for (int i = 0; i < 2; i++) begin
            smp = (i == 0) ? s.ld : s.rn;
            m_evt[i] = 0;
            if (smp != m_lvl[i]) begin
                m_stable[i]++;
                if (m_stable[i] == D) begin
                    m_lvl[i] = smp; m_stable[i] = 0; m_evt[i] = smp;
                end
            end else begin
                m_stable[i] = 0;
            end
        end
        e_en = 0; e_ld = 0;
        if (m_in_load) begin
            m_in_load = 0; m_mode = m_ret; m_run_age = 0; e_run = m_ret;
        end else if (ev_ld) begin
            m_in_load = 1; m_ret = ev_rn ? !m_mode : m_mode;
            e_ld = 1; e_dat = s.dat; e_run = m_mode;
        end else if (ev_rn) begin
            m_mode = !m_mode; m_run_age = 0; e_run = m_mode;
        end else if (m_mode) begin
            m_run_age++; e_en = (m_run_age % P == 0); e_run = 1;
        end else begin
            e_run = 0;
        end
        e_dir = s.dir;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else      model_step();
    end

    always @(negedge clk) begin
        chk("m_cnt_en",   cnt_en,   e_en);
        chk("m_cnt_load", cnt_load, e_ld);
        chk("m_cnt_dir",  cnt_dir,  e_dir);
        chk("m_cnt_data", cnt_data, e_dat);
        chk("m_running",  running,  e_run);
    end

    task automatic wait_sig(input int which, input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if ((which == 0 && running) || (which == 1 && cnt_en) || (which == 2 && cnt_load)) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n, act, loads, hold;
        rst = 1'b0; load_btn = 0; run_btn = 0; up_down_sw = 0; data_sw = '0;

        // Reset held with inputs wiggling, then idle.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            run_btn = i[0]; load_btn = ~i[0]; up_down_sw = i[0]; data_sw = i[3:0] + 4'd7;
            chk("rst_outputs", {running, cnt_en, cnt_load, cnt_dir, cnt_data}, 0);
        end
        @(negedge clk);
        run_btn = 0; load_btn = 0; up_down_sw = 0; data_sw = '0;
        rst = 1'b1;
        act = 0;
        repeat (50) begin
            @(negedge clk);
            act += int'(running) + int'(cnt_en) + int'(cnt_load);
        end
        chk("idle_activity", act, 0);

        // Bouncing run button never settles.
        for (int i = 0; i < 20; i++) begin
            run_btn = (i % 4) < 2;
            @(negedge clk);
        end
        run_btn = 0;
        wait_sig(0, 20, n);
        chk("bounce_no_run", n, -1);

        up_down_sw = 1;
        repeat (2) @(negedge clk);
        chk("dir_after_2", cnt_dir, 0);
        @(negedge clk);
        chk("dir_after_3", cnt_dir, 1);

        // Long run press: one transition, periodic ticks.
        run_btn = 1;
        wait_sig(0, 20, n);
        chk("run_latency", n, 7);
        wait_sig(1, 30, n);
        chk("first_tick", n, 10);
        repeat (3) @(negedge clk);
        run_btn = 0;
        wait_sig(1, 30, n);
        chk("tick_period", n, 7);
        chk("still_running", running, 1);
        repeat (4) @(negedge clk);

        // Load while running.
        data_sw = 4'hA; load_btn = 1;
        wait_sig(2, 20, n);
        chk("load_latency", n, 7);
        chk("load_data", cnt_data, 4'hA);
        chk("load_no_en", cnt_en, 0);
        chk("load_running", running, 1);
        data_sw = 4'h3;
        @(negedge clk);
        chk("load_one_cycle", cnt_load, 0);
        chk("load_data_held", cnt_data, 4'hA);
        wait_sig(1, 30, n);
        chk("tick_after_load", n, 10);
        load_btn = 0;
        repeat (10) @(negedge clk);

        // Simultaneous events in RUN: load, then PAUSE.
        run_btn = 1; load_btn = 1; data_sw = 4'h5;
        wait_sig(2, 20, n);
        chk("both_run_latency", n, 7);
        chk("both_run_data", cnt_data, 4'h5);
        chk("both_run_in_load", running, 1);
        @(negedge clk);
        chk("both_run_to_pause", running, 0);
        loads = 0;
        repeat (14) begin
            @(negedge clk);
            loads += int'(cnt_load);
        end
        chk("both_run_single_load", loads, 0);
        run_btn = 0; load_btn = 0;
        repeat (10) @(negedge clk);

        // Simultaneous events in PAUSE: load, then RUN.
        run_btn = 1; load_btn = 1; data_sw = 4'hC;
        wait_sig(2, 20, n);
        chk("both_pause_latency", n, 7);
        chk("both_pause_data", cnt_data, 4'hC);
        chk("both_pause_in_load", running, 0);
        @(negedge clk);
        chk("both_pause_to_run", running, 1);
        run_btn = 0; load_btn = 0;
        repeat (10) @(negedge clk);

        // Asynchronous reset mid-RUN.
        wait_sig(1, 30, n);
        chk("pre_reset_running", running, 1);
        chk("pre_reset_dir", cnt_dir, 1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk("async_reset_outputs", {running, cnt_en, cnt_load, cnt_dir, cnt_data}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        wait_sig(0, 20, n);
        chk("after_reset_pause", n, -1);

        // Randomised traffic with occasional asynchronous resets.
        for (int s = 0; s < 400; s++) begin
            if ($urandom_range(0, 2) == 0) run_btn = ~run_btn;
            if ($urandom_range(0, 2) == 0) load_btn = ~load_btn;
            if ($urandom_range(0, 4) == 0) up_down_sw = ~up_down_sw;
            data_sw = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 59) == 0) begin
                @(posedge clk);
                #($urandom_range(1, 4)) rst = 1'b0;
                repeat (2) @(negedge clk);
                rst = 1'b1;
            end
            hold = $urandom_range(1, 12);
            repeat (hold) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
Control and sequencing block for the 4-bit up/down counter datapath on the MAX10 board. It conditions raw push-button and switch inputs by synchronising and debouncing them. It runs a PAUSE/RUN/LOAD state machine and derives a slow count-enable tick from the 50 MHz clock. It drives the counter's enable, load, direction and load-data inputs, so the counter advances at a human-visible rate and loads exactly once per button press.

Parameters:
CLK_HZ, 50000000, input clock frequency in Hz
TICK_HZ, 1, count-enable pulse rate in Hz; CLK_HZ/TICK_HZ must be an integer >= 2
DEBOUNCE_CYCLES, 1000000, consecutive stable samples needed to accept a button level (20 ms at 50 MHz)
DATA_W, 4, width of load data

Ports:
clk  in  1  system clock, MAX10_CLK1_50
rst  in  1  asynchronous, active-low reset
load_btn  in  1  raw load button, active-high (board inversion done upstream), asynchronous
run_btn  in  1  raw run/pause toggle button, active-high, asynchronous
up_down_sw  in  1  raw direction switch, 1 = up
data_sw  in  DATA_W  raw load-value switches
cnt_en  out  1  one-cycle count-enable pulse to counter
cnt_load  out  1  one-cycle load strobe to counter
cnt_dir  out  1  registered direction to counter, 1 = up
cnt_data  out  DATA_W  value presented with cnt_load
running  out  1  1 while in RUN, or in LOAD entered from RUN

Behaviour:
- Reset: rst=0 forces, immediately and without a clock edge, state=PAUSE, prescaler=0, debounce counters=0, debounced levels=0, synchroniser flops=0, return_state=PAUSE. All outputs are 0 during reset.
- Input conditioning: every raw input passes through a 2-FF synchroniser. cnt_dir is the synchronised up_down_sw, registered once more; it is not debounced.
- Debounce, per button:
  - A counter increments while the synchronised sample differs from the debounced level, and clears to 0 when they match.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level takes the sample and the counter clears.
  - A rising edge of the debounced level produces a one-cycle event (run_evt or load_evt) on the following cycle.
  - Latency from raw rising edge to event = 2 + DEBOUNCE_CYCLES + 1 cycles.
  - Releasing a button generates no event. Holding a button generates exactly one event.
- FSM states:
  - PAUSE: cnt_en=0, prescaler held at 0. run_evt -> RUN. load_evt -> LOAD with return_state=PAUSE.
  - RUN: prescaler counts 0..CLK_HZ/TICK_HZ-1 and wraps to 0. cnt_en=1 for exactly the cycle in which the prescaler equals its terminal count. run_evt -> PAUSE and clears the prescaler. load_evt -> LOAD with return_state=RUN.
  - LOAD: lasts exactly 1 cycle. cnt_load=1 and cnt_data = data_sw value registered on the load_evt cycle. Prescaler clears to 0. Next state = return_state.
- cnt_data holds its last loaded value outside LOAD.
- Timing after entering RUN: the first cnt_en pulse occurs CLK_HZ/TICK_HZ cycles after entry. This applies whether entry is from PAUSE or from LOAD, so each interval is a full period.
- Simultaneous run_evt and load_evt:
  - Load has priority: go to LOAD.
  - return_state is the toggled value (RUN<->PAUSE) of the state in which both events arrived.
- Events arriving while in LOAD are ignored (they are dropped, not queued).
- cnt_en and cnt_load are never high in the same cycle.
- A direction change takes effect on cnt_dir 3 cycles after the raw switch edge and does not disturb the prescaler.
- Reset asserted mid-operation aborts any LOAD in progress; no cnt_load pulse completes.

Test Plan (CLK_HZ=10, TICK_HZ=1, DEBOUNCE_CYCLES=4):
1. Hold rst=0 for 5 cycles with inputs toggling, then release and idle 50 cycles -> all outputs 0 throughout, no cnt_en or cnt_load pulse.
2. run_btn=1 held for 20 cycles -> running=1 seven cycles after the press. cnt_en pulses once every 10 cycles, first pulse 10 cycles after entering RUN. Only one state change despite the long hold.
3. run_btn toggled every 2 cycles for 20 cycles, then held at 0 -> no run_evt; state stays PAUSE and running=0.
4. In RUN, data_sw=4'hA, press load_btn -> exactly one cycle with cnt_load=1 and cnt_data=4'hA, no cnt_en in that cycle. Returns to RUN with the next cnt_en exactly 10 cycles after the LOAD cycle.
5. In PAUSE, raw edges of run_btn and load_btn aligned so both events occur on the same cycle -> one cnt_load pulse, then RUN. Repeating the same test in RUN -> one cnt_load pulse, then PAUSE.
6. Drop rst to 0 asynchronously, between clock edges, mid-RUN -> running, cnt_en, cnt_load and cnt_dir go to 0 before the next clock edge. After release the block is in PAUSE.
